// File: rtl/tlut_pkg.sv
// Shared constants and types for the temporal-LUT matrix-multiply datapath.
// Widths here are the defaults used by the TLUT array and adder tree.
package tlut_pkg;

   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned TILE_W     = 8;
   localparam int unsigned SWEEP_LEN  = 2**DATA_WIDTH;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SWEEP,
      REDUCE,
      RESP,
      DONE
   } sched_state_e;

endpackage

// File: rtl/tlut_sweep_cnt.sv
// Temporal code-point counter driving the TLUT product array.
// wrap_o flags the last code point of a sweep while counting.
module tlut_sweep_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic         clr_i,
   output logic [W-1:0] count_o,
   output logic         wrap_o
);

   logic [W-1:0] cnt_q, cnt_d;

   assign count_o = cnt_q;
   assign wrap_o  = en_i && (cnt_q == {W{1'b1}});

   // Natural overflow returns the counter to 0 after the last point.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tlut_mm_sched.sv
// Job sequencer: per tile, load operands, sweep all code points,
// wait out the adder tree, then hand one result beat to the consumer.
module tlut_mm_sched #(
   parameter int unsigned DATA_WIDTH = tlut_pkg::DATA_WIDTH,
   parameter int unsigned TILE_W     = tlut_pkg::TILE_W,
   parameter int unsigned ADD_LAT    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic [TILE_W-1:0]     num_tiles,
   input  logic                  clear,
   output logic                  op_load,
   output logic [TILE_W-1:0]     tile_idx,
   output logic                  sweep_en,
   output logic [DATA_WIDTH-1:0] sweep_cnt,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic                  res_last,
   output logic                  job_done,
   output logic                  busy
);

   import tlut_pkg::*;

   localparam int unsigned RW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

   sched_state_e      state_q, state_d;
   logic [TILE_W-1:0] ntiles_q, ntiles_d;
   logic [TILE_W-1:0] tile_q, tile_d;
   logic [RW-1:0]     red_q, red_d;
   logic              wrap;
   logic              last;

   tlut_sweep_cnt #(
      .W (DATA_WIDTH)
   ) u_sweep (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (state_q == SWEEP),
      .clr_i   (clear),
      .count_o (sweep_cnt),
      .wrap_o  (wrap)
   );

   assign last        = (tile_q == ntiles_q - TILE_W'(1));
   assign start_ready = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign op_load     = (state_q == LOAD);
   assign sweep_en    = (state_q == SWEEP);
   assign res_valid   = (state_q == RESP);
   assign res_last    = res_valid && last;
   assign job_done    = (state_q == DONE);
   assign tile_idx    = tile_q;

   always_comb begin
      state_d  = state_q;
      ntiles_d = ntiles_q;
      tile_d   = tile_q;
      red_d    = red_q;
      if (clear) begin
         state_d  = IDLE;
         ntiles_d = '0;
         tile_d   = '0;
         red_d    = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_valid) begin
                  ntiles_d = num_tiles;
                  tile_d   = '0;
                  state_d  = (num_tiles == '0) ? DONE : LOAD;
               end
            end
            LOAD: state_d = SWEEP;
            SWEEP: begin
               if (wrap) begin
                  state_d = REDUCE;
                  red_d   = RW'(ADD_LAT - 1);
               end
            end
            REDUCE: begin
               if (red_q == '0) begin
                  state_d = RESP;
               end else begin
                  red_d = red_q - RW'(1);
               end
            end
            RESP: begin
               if (res_ready) begin
                  if (last) begin
                     state_d = DONE;
                  end else begin
                     tile_d  = tile_q + TILE_W'(1);
                     state_d = LOAD;
                  end
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ntiles_q <= '0;
         tile_q   <= '0;
         red_q    <= '0;
      end else begin
         state_q  <= state_d;
         ntiles_q <= ntiles_d;
         tile_q   <= tile_d;
         red_q    <= red_d;
      end
   end

endmodule

// File: tb/tb_tlut_mm_sched.sv
// Directed bench for tlut_mm_sched (DATA_WIDTH=2, TILE_W=4).
// A second instance with ADD_LAT=3 covers the longer reduce gap.
module tb_tlut_mm_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_valid, start_valid3;
   logic       clear, res_ready;
   logic [3:0] num_tiles;

   logic       start_ready, op_load, sweep_en;
   logic       res_valid, res_last, job_done, busy;
   logic [3:0] tile_idx;
   logic [1:0] sweep_cnt;

   logic       start_ready3, op_load3, sweep_en3;
   logic       res_valid3, res_last3, job_done3, busy3;
   logic [3:0] tile_idx3;
   logic [1:0] sweep_cnt3;

   int checks = 0;
   int errors = 0;
   int loads, beats;

   always #5 clk = ~clk;

   tlut_mm_sched #(
      .DATA_WIDTH (2),
      .TILE_W     (4),
      .ADD_LAT    (1)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .num_tiles   (num_tiles),
      .clear       (clear),
      .op_load     (op_load),
      .tile_idx    (tile_idx),
      .sweep_en    (sweep_en),
      .sweep_cnt   (sweep_cnt),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_last    (res_last),
      .job_done    (job_done),
      .busy        (busy)
   );

   tlut_mm_sched #(
      .DATA_WIDTH (2),
      .TILE_W     (4),
      .ADD_LAT    (3)
   ) u_dut3 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid3),
      .start_ready (start_ready3),
      .num_tiles   (num_tiles),
      .clear       (clear),
      .op_load     (op_load3),
      .tile_idx    (tile_idx3),
      .sweep_en    (sweep_en3),
      .sweep_cnt   (sweep_cnt3),
      .res_valid   (res_valid3),
      .res_ready   (res_ready),
      .res_last    (res_last3),
      .job_done    (job_done3),
      .busy        (busy3)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Handshake cycle is cycle 0; returns in cycle 1.
   task automatic go(input logic [3:0] n);
      num_tiles   = n;
      start_valid = 1'b1;
      chk("go_start_ready", start_ready, 1);
      step();
      start_valid = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      start_valid  = 1'b0;
      start_valid3 = 1'b0;
      clear        = 1'b0;
      res_ready    = 1'b1;
      num_tiles    = 4'd0;
      #12;
      chk("rst_start_ready", start_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_outs", {op_load, sweep_en, res_valid, job_done}, 0);
      chk("rst_tile", tile_idx, 0);
      chk("rst_cnt", sweep_cnt, 0);
      rst_n = 1'b1;
      step();

      // 1: single tile
      go(4'd1);
      chk("t1_op_load", op_load, 1);
      chk("t1_busy", busy, 1);
      for (int c = 2; c <= 5; c++) begin
         step();
         chk("t1_sweep_en", sweep_en, 1);
         chk("t1_sweep_cnt", sweep_cnt, c - 2);
      end
      step();
      chk("t1_reduce", {res_valid, sweep_en, sweep_cnt}, 0);
      step();
      chk("t1_res_valid", res_valid, 1);
      chk("t1_res_last", res_last, 1);
      step();
      chk("t1_job_done", job_done, 1);
      step();
      chk("t1_idle", {start_ready, job_done}, 2'b10);

      // 2: three tiles, num_tiles changed after handshake
      go(4'd3);
      num_tiles = 4'd1;
      loads = 0;
      beats = 0;
      for (int c = 1; c <= 22; c++) begin
         if (op_load) loads++;
         if (res_valid) begin
            chk("t2_beat_cyc", c, 7 * (beats + 1));
            chk("t2_tile_idx", tile_idx, beats);
            chk("t2_res_last", res_last, (beats == 2));
            beats++;
         end
         if (c == 22) chk("t2_job_done", job_done, 1);
         if (c < 22) step();
      end
      chk("t2_loads", loads, 3);
      chk("t2_beats", beats, 3);
      step();

      // 3: backpressure
      res_ready = 1'b0;
      go(4'd2);
      step(6);
      for (int c = 7; c <= 11; c++) begin
         chk("t3_hold", {res_valid, res_last, tile_idx}, 6'b10_0000);
         step();
      end
      chk("t3_hold12", res_valid, 1);
      res_ready = 1'b1;
      step();
      chk("t3_op_load", op_load, 1);
      chk("t3_tile1", tile_idx, 1);
      step(6);
      chk("t3_last", {res_valid, res_last}, 2'b11);
      step();
      chk("t3_job_done", job_done, 1);
      step();

      // 4: empty job
      go(4'd0);
      chk("t4_job_done", job_done, 1);
      chk("t4_quiet", {op_load, sweep_en, res_valid}, 0);
      step();
      chk("t4_idle", {start_ready, job_done, busy}, 3'b100);

      // 5a: clear mid-sweep, then clear+start together
      go(4'd1);
      step(3);
      chk("t5_cnt2", sweep_cnt, 2);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("t5_clr_idle", {busy, start_ready, sweep_en}, 3'b010);
      chk("t5_clr_cnt", sweep_cnt, 0);
      chk("t5_clr_done", job_done, 0);
      step();
      chk("t5_no_done", job_done, 0);
      clear       = 1'b1;
      start_valid = 1'b1;
      num_tiles   = 4'd1;
      step();
      clear       = 1'b0;
      start_valid = 1'b0;
      chk("t5_clr_start", {busy, op_load}, 0);

      // 5b: async reset during tile 1 response
      go(4'd2);
      step(6);
      chk("t5_resp0", res_valid, 1);
      step();
      res_ready = 1'b0;
      step(6);
      chk("t5_resp1", {res_valid, tile_idx}, 5'b1_0001);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_outs", {res_valid, res_last, op_load, job_done}, 0);
      chk("t5_rst_idle", {busy, start_ready}, 2'b01);
      chk("t5_rst_tile", tile_idx, 0);
      chk("t5_rst_cnt", sweep_cnt, 0);
      rst_n     = 1'b1;
      res_ready = 1'b1;
      step();

      // 6: start held during a busy job
      num_tiles   = 4'd1;
      start_valid = 1'b1;
      step();
      loads = 0;
      for (int c = 1; c <= 8; c++) begin
         if (op_load) loads++;
         chk("t6_not_ready", start_ready, 0);
         if (c == 8) start_valid = 1'b0;
         step();
      end
      chk("t6_idle", start_ready, 1);
      step();
      chk("t6_single_job", {loads, busy}, {32'd1, 1'b0});

      // 6b: ADD_LAT=3 instance
      start_valid3 = 1'b1;
      step();
      start_valid3 = 1'b0;
      chk("t6_l3_load", op_load3, 1);
      step(5);
      for (int c = 6; c <= 8; c++) begin
         chk("t6_l3_reduce", {res_valid3, busy3}, 2'b01);
         step();
      end
      chk("t6_l3_res", {res_valid3, res_last3}, 2'b11);
      step();
      chk("t6_l3_done", job_done3, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
